pc_counter: RTL and testbench
=============================

PC_COUNTER -- requirements
Module: pc_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register and data width in bits (2..32).
REQ-002 SHALL have parameter STEP, default 1, increment/decrement amount (1..2^WIDTH-1).
REQ-003 SHALL have parameter LIMIT, default 2^WIDTH-1, highest count value before wrap (STEP <= LIMIT <= 2^WIDTH-1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in  input  WIDTH  load value; bit 0 least significant.
REQ-007 SHALL have port load  input  1  load in into count.
REQ-008 SHALL have port inc  input  1  count up by STEP.
REQ-009 SHALL have port dec  input  1  count down by STEP.
REQ-010 SHALL have port out  output  WIDTH  registered count; bit 0 least significant.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse: last update crossed a boundary.
REQ-012 SHALL have port ovf  output  1  sticky flag: a boundary crossing occurred since last reset/load.

Function
REQ-013 Priority per edge SHALL be reset > load > (inc xor dec) > hold.
REQ-014 load=1: out <= in unmodified (even if in > LIMIT), wrap <= 0, ovf <= 0, regardless of inc/dec.
REQ-015 inc=1, dec=0: sum = out + STEP computed at WIDTH+1 bits; if sum <= LIMIT then out <= sum, wrap <= 0; else boundary crossing.
REQ-016 dec=1, inc=0: if out >= STEP and out <= LIMIT then out <= out - STEP, wrap <= 0; else boundary crossing.
REQ-017 inc=1 and dec=1 together, or both 0: out and ovf hold, wrap <= 0.
REQ-018 Up crossing (wrap mode): out <= 0; down crossing: out <= LIMIT.
REQ-019 Any boundary crossing SHALL set wrap <= 1 for exactly that cycle and set ovf <= 1.
REQ-020 wrap SHALL be 0 on every cycle not caused by a crossing; back-to-back crossings give consecutive wrap=1 cycles.
REQ-021 Latency: out, wrap, ovf reflect inputs sampled at edge N immediately after edge N (one cycle); no combinational input-to-output path.
REQ-022 ovf SHALL only clear via reset or load.

Reset
REQ-023 reset=1 at an edge: out <= 0, wrap <= 0, ovf <= 0, overriding load/inc/dec.
REQ-024 Reset asserted mid-count SHALL discard any pending operation; counting resumes from 0 the first edge reset is low.
REQ-025 Before first reset, output values are unspecified; bench applies reset at start.

Configuration
REQ-026 Macro PC_COUNTER_SAT_EN SHALL select saturation instead of wrap.
REQ-027 Defined: up crossing sets out <= LIMIT, down crossing sets out <= 0; wrap pulses and ovf sets as in REQ-019; further inc at LIMIT holds LIMIT with wrap=1.
REQ-028 Undefined: wrap behaviour of REQ-018 applies; no saturation logic present.

Verification
REQ-029 WIDTH=16,STEP=1: reset, inc x5 -> out 0,1,2,3,4,5; wrap=0, ovf=0 throughout.
REQ-030 WIDTH=16,STEP=1: load 0xFFFE, inc x2 -> out 0xFFFF then 0x0000, wrap=1 only on second cycle, ovf=1 thereafter; load 0x1234 -> ovf=0.
REQ-031 WIDTH=8,STEP=3,LIMIT=9: load 6, inc -> 9; inc -> 0, wrap=1; dec -> 9, wrap=1; dec -> 6, wrap=0.
REQ-032 Priority: load=1,inc=1,in=0x0040 -> out 0x0040; inc=1,dec=1 -> holds 0x0040; reset=1,load=1 -> out 0, ovf 0.
REQ-033 PC_COUNTER_SAT_EN, WIDTH=8,STEP=1: load 0xFE, inc x3 -> 0xFF, 0xFF, 0xFF with wrap 0,1,1; load 0x01, dec x2 -> 0x00, 0x00 with wrap 0,1.
REQ-034 Reset mid-count: counting at out=0x0010 with inc held, reset one cycle -> out 0 next cycle, then 1,2,... after release.

Source files
------------

// File: rtl/pc_counter.sv
// Loadable up/down counter with wrap pulse and sticky overflow flag.
// Define PC_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module pc_counter #(
    parameter int unsigned     WIDTH = 16,
    parameter logic [WIDTH-1:0] STEP  = 1,
    parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             ovf
);

`ifdef PC_COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] UP_VAL = LIMIT;
    localparam logic [WIDTH-1:0] DN_VAL = '0;
`else
    localparam logic [WIDTH-1:0] UP_VAL = '0;
    localparam logic [WIDTH-1:0] DN_VAL = LIMIT;
`endif

    logic [WIDTH:0]   sum;
    logic             up_ok;
    logic             dn_ok;
    logic             do_up;
    logic             do_dn;
    logic [WIDTH-1:0] out_nx;
    logic             wrap_nx;
    logic             ovf_nx;

    // One extra bit so the sum never aliases back below LIMIT.
    assign sum   = {1'b0, out} + {1'b0, STEP};
    assign up_ok = sum <= {1'b0, LIMIT};
    assign dn_ok = (out >= STEP) && (out <= LIMIT);
    assign do_up = inc & ~dec;
    assign do_dn = dec & ~inc;

    always_comb begin
        out_nx  = out;
        wrap_nx = 1'b0;
        ovf_nx  = ovf;
        priority case (1'b1)
            load: begin
                out_nx = in;
                ovf_nx = 1'b0;
            end
            do_up: begin
                if (up_ok) begin
                    out_nx = sum[WIDTH-1:0];
                end else begin
                    out_nx  = UP_VAL;
                    wrap_nx = 1'b1;
                    ovf_nx  = 1'b1;
                end
            end
            do_dn: begin
                if (dn_ok) begin
                    out_nx = out - STEP;
                end else begin
                    out_nx  = DN_VAL;
                    wrap_nx = 1'b1;
                    ovf_nx  = 1'b1;
                end
            end
            default: begin
                out_nx  = out;
                wrap_nx = 1'b0;
                ovf_nx  = ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            out  <= out_nx;
            wrap <= wrap_nx;
            ovf  <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_pc_counter.sv
// Directed bench for pc_counter: three instances cover the
// default, small-step and 8-bit configurations in both build modes.
module tb_pc_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        ra = 0, la = 0, ia = 0, da = 0;
    logic [15:0] ina = '0, outa;
    logic        wa, oa;

    logic        rb = 0, lb = 0, ib = 0, db = 0;
    logic [7:0]  inb = '0, outb;
    logic        wb, ob;

    logic        rc = 0, lc = 0, ic = 0, dc = 0;
    logic [7:0]  inc_v = '0, outc;
    logic        wc, oc;

    pc_counter #(.WIDTH(16), .STEP(16'd1)) u_a (
        .clk(clk), .reset(ra), .in(ina), .load(la),
        .inc(ia), .dec(da), .out(outa), .wrap(wa), .ovf(oa)
    );

    pc_counter #(.WIDTH(8), .STEP(8'd3), .LIMIT(8'd9)) u_b (
        .clk(clk), .reset(rb), .in(inb), .load(lb),
        .inc(ib), .dec(db), .out(outb), .wrap(wb), .ovf(ob)
    );

    pc_counter #(.WIDTH(8), .STEP(8'd1)) u_c (
        .clk(clk), .reset(rc), .in(inc_v), .load(lc),
        .inc(ic), .dec(dc), .out(outc), .wrap(wc), .ovf(oc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(string nm, logic [15:0] eo, logic ew, logic eov);
        n_checks++;
        if ({outa, wa, oa} !== {eo, ew, eov}) begin
            n_fail++;
            $display("FAIL %s: got out=%h wrap=%b ovf=%b want out=%h wrap=%b ovf=%b",
                     nm, outa, wa, oa, eo, ew, eov);
        end
    endtask

    task automatic test_reset();
        ra = 1; rb = 1; rc = 1;
        la = 1; ina = 16'hABCD; ia = 1;
        tick();
        ra = 0; rb = 0; rc = 0; la = 0; ia = 0;
        n_checks++;
        if ({outa, wa, oa} !== {16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got %h/%b/%b want 0000/0/0", outa, wa, oa);
        end
        n_checks++;
        if ({outb, wb, ob, outc, wc, oc} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_bc: got %h/%b/%b %h/%b/%b want zeros",
                     outb, wb, ob, outc, wc, oc);
        end
    endtask

    task automatic test_count();
        ia = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if ({outa, wa, oa} !== {i[15:0], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL count%0d: got %h/%b/%b want %h/0/0",
                         i, outa, wa, oa, i[15:0]);
            end
        end
        ia = 0;
    endtask

    task automatic test_wrap16();
        la = 1; ina = 16'hFFFE;
        tick();
        la = 0;
        chk_a("load_fffe", 16'hFFFE, 0, 0);
        ia = 1;
        tick();
        chk_a("inc_ffff", 16'hFFFF, 0, 0);
        tick();
`ifdef PC_COUNTER_SAT_EN
        chk_a("inc_cross", 16'hFFFF, 1, 1);
`else
        chk_a("inc_cross", 16'h0000, 1, 1);
`endif
        ia = 0;
        tick();
`ifdef PC_COUNTER_SAT_EN
        chk_a("hold_sticky", 16'hFFFF, 0, 1);
`else
        chk_a("hold_sticky", 16'h0000, 0, 1);
`endif
        la = 1; ina = 16'h1234;
        tick();
        la = 0;
        chk_a("load_clr", 16'h1234, 0, 0);
    endtask

    task automatic test_step3();
        logic [7:0] eo[5];
        logic       ew[5];
        logic       eov[5];
        logic       ld[5];
        logic       up[5];
`ifdef PC_COUNTER_SAT_EN
        eo = '{8'd6, 8'd9, 8'd9, 8'd6, 8'd3};
        ew = '{0, 0, 1, 0, 0};
`else
        eo = '{8'd6, 8'd9, 8'd0, 8'd9, 8'd6};
        ew = '{0, 0, 1, 1, 0};
`endif
        eov = '{0, 0, 1, 1, 1};
        ld  = '{1, 0, 0, 0, 0};
        up  = '{0, 1, 1, 0, 0};
        inb = 8'd6;
        for (int i = 0; i < 5; i++) begin
            lb = ld[i];
            ib = up[i];
            db = !ld[i] && !up[i];
            tick();
            n_checks++;
            if ({outb, wb, ob} !== {eo[i], ew[i], eov[i]}) begin
                n_fail++;
                $display("FAIL step3_%0d: got %0d/%b/%b want %0d/%b/%b",
                         i, outb, wb, ob, eo[i], ew[i], eov[i]);
            end
        end
        lb = 0; ib = 0; db = 0;
    endtask

    task automatic test_back_to_back();
        lb = 1; inb = 8'd10;
        tick();
        lb = 0;
        n_checks++;
        if ({outb, wb, ob} !== {8'd10, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_load: got %0d/%b/%b want 10/0/0", outb, wb, ob);
        end
        ib = 1;
        tick();
        ib = 0;
        n_checks++;
`ifdef PC_COUNTER_SAT_EN
        if ({outb, wb, ob} !== {8'd9, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_inc: got %0d/%b/%b want 9/1/1", outb, wb, ob);
        end
`else
        if ({outb, wb, ob} !== {8'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_inc: got %0d/%b/%b want 0/1/1", outb, wb, ob);
        end
`endif
        db = 1;
        tick();
        db = 0;
        n_checks++;
`ifdef PC_COUNTER_SAT_EN
        if ({outb, wb, ob} !== {8'd6, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_dec: got %0d/%b/%b want 6/0/1", outb, wb, ob);
        end
`else
        if ({outb, wb, ob} !== {8'd9, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_dec: got %0d/%b/%b want 9/1/1", outb, wb, ob);
        end
`endif
        ib = 1; db = 1;
        tick();
        ib = 0; db = 0;
        n_checks++;
        if ({wb, ob} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_hold: got wrap=%b ovf=%b want 0/1", wb, ob);
        end
    endtask

    task automatic test_8bit_bounds();
        logic [7:0] eo[7];
        logic       ew[7];
        logic       eov[7];
        int         op[7];
`ifdef PC_COUNTER_SAT_EN
        eo = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00};
        ew = '{0, 0, 1, 1, 0, 0, 1};
`else
        eo = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h00, 8'hFF};
        ew = '{0, 0, 1, 0, 0, 0, 1};
`endif
        eov = '{0, 0, 1, 1, 0, 0, 1};
        op  = '{0, 1, 1, 1, 3, 2, 2};
        for (int i = 0; i < 7; i++) begin
            lc = (op[i] == 0) || (op[i] == 3);
            inc_v = (op[i] == 0) ? 8'hFE : 8'h01;
            ic = (op[i] == 1);
            dc = (op[i] == 2);
            tick();
            n_checks++;
            if ({outc, wc, oc} !== {eo[i], ew[i], eov[i]}) begin
                n_fail++;
                $display("FAIL bounds8_%0d: got %h/%b/%b want %h/%b/%b",
                         i, outc, wc, oc, eo[i], ew[i], eov[i]);
            end
        end
        lc = 0; ic = 0; dc = 0;
    endtask

    task automatic test_priority();
        la = 1; ia = 1; ina = 16'h0040;
        tick();
        la = 0;
        chk_a("load_over_inc", 16'h0040, 0, 0);
        ia = 1; da = 1;
        tick();
        chk_a("inc_dec_hold", 16'h0040, 0, 0);
        ia = 0; da = 0;
        ra = 1; la = 1; ina = 16'h0055;
        tick();
        ra = 0; la = 0;
        chk_a("reset_over_load", 16'h0000, 0, 0);
    endtask

    task automatic test_reset_mid();
        la = 1; ina = 16'h000F;
        tick();
        la = 0; ia = 1;
        tick();
        chk_a("mid_0010", 16'h0010, 0, 0);
        ra = 1;
        tick();
        ra = 0;
        chk_a("mid_reset", 16'h0000, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({outa, wa, oa} !== {i[15:0], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_resume%0d: got %h/%b/%b want %h/0/0",
                         i, outa, wa, oa, i[15:0]);
            end
        end
        ia = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count();
        test_wrap16();
        test_step3();
        test_back_to_back();
        test_8bit_bounds();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
